// File: rtl/memory_port_arbiter_if.sv
// Bundle of PE request/response, memory-side and stall-profiling signals
// around the data-memory port arbiter.
interface memory_port_arbiter_if #(
  parameter int NUM_PORTS           = 4,
  parameter int DATA_WIDTH          = 32,
  parameter int ADDRESS_WIDTH       = 16,
  parameter int STALL_COUNTER_WIDTH = 16
);
  logic [NUM_PORTS-1:0]                     req_valid;
  logic [NUM_PORTS-1:0]                     req_write;
  logic [NUM_PORTS*ADDRESS_WIDTH-1:0]       req_address;
  logic [NUM_PORTS*DATA_WIDTH-1:0]          req_data;
  logic [NUM_PORTS-1:0]                     req_ready;
  logic [NUM_PORTS-1:0]                     rsp_valid;
  logic [DATA_WIDTH-1:0]                    rsp_data;
  logic [ADDRESS_WIDTH-1:0]                 mem_address;
  logic                                     mem_write;
  logic [DATA_WIDTH-1:0]                    mem_write_data;
  logic [DATA_WIDTH-1:0]                    mem_read_data;
  logic                                     stall_clear;
  logic [NUM_PORTS*STALL_COUNTER_WIDTH-1:0] stall_count;

  modport slave (
    input  req_valid, req_write, req_address, req_data, mem_read_data, stall_clear,
    output req_ready, rsp_valid, rsp_data, mem_address, mem_write, mem_write_data, stall_count
  );

  modport master (
    output req_valid, req_write, req_address, req_data, mem_read_data, stall_clear,
    input  req_ready, rsp_valid, rsp_data, mem_address, mem_write, mem_write_data, stall_count
  );
endinterface

// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter multiplexing NUM_PORTS PE load/store ports onto one
// registered-output data-memory port, with per-port saturating stall counters.
module memory_port_arbiter #(
  parameter int NUM_PORTS           = 4,
  parameter int DATA_WIDTH          = 32,
  parameter int ADDRESS_WIDTH       = 16,
  parameter int STALL_COUNTER_WIDTH = 16
) (
  input logic                  clk,
  input logic                  reset,
  memory_port_arbiter_if.slave bus
);
  localparam int               PTR_W       = $clog2(NUM_PORTS);
  localparam logic [PTR_W:0]   NUM_PORTS_W = (PTR_W+1)'(NUM_PORTS);
  localparam logic [PTR_W-1:0] LAST_PORT   = PTR_W'(NUM_PORTS - 1);

  logic [PTR_W-1:0]               r_rrPtr;
  logic [NUM_PORTS-1:0]           r_rspOnehot;
  logic [STALL_COUNTER_WIDTH-1:0] r_stallCnt [NUM_PORTS];

  logic [NUM_PORTS-1:0]                     w_grant;
  logic [PTR_W-1:0]                         w_grantIdx;
  logic                                     w_found;
  logic [PTR_W:0]                           w_scanIdx;
  logic                                     w_grantWrite;
  logic [ADDRESS_WIDTH-1:0]                 w_memAddress;
  logic [DATA_WIDTH-1:0]                    w_memWriteData;
  logic [NUM_PORTS*STALL_COUNTER_WIDTH-1:0] w_stallPacked;

  // Scan from r_rrPtr upward with wrap; the first valid port wins.
  always_comb begin
    w_grant    = '0;
    w_grantIdx = '0;
    w_found    = 1'b0;
    w_scanIdx  = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      w_scanIdx = {1'b0, r_rrPtr} + (PTR_W+1)'(o);
      if (w_scanIdx >= NUM_PORTS_W) begin
        w_scanIdx = w_scanIdx - NUM_PORTS_W;
      end
      if (!w_found && bus.req_valid[w_scanIdx[PTR_W-1:0]]) begin
        w_found                          = 1'b1;
        w_grantIdx                       = w_scanIdx[PTR_W-1:0];
        w_grant[w_scanIdx[PTR_W-1:0]]    = 1'b1;
      end
    end
  end

  always_comb begin
    w_memAddress   = '0;
    w_memWriteData = '0;
    w_grantWrite   = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_grant[i]) begin
        w_memAddress   = bus.req_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        w_memWriteData = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_grantWrite   = bus.req_write[i];
      end
    end
  end

  always_comb begin
    w_stallPacked = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_stallPacked[i*STALL_COUNTER_WIDTH +: STALL_COUNTER_WIDTH] = r_stallCnt[i];
    end
  end

  assign bus.req_ready      = w_grant;
  assign bus.mem_address    = w_memAddress;
  assign bus.mem_write      = w_found & w_grantWrite;
  assign bus.mem_write_data = w_memWriteData;
  assign bus.rsp_valid      = r_rspOnehot;
  assign bus.rsp_data       = bus.mem_read_data;
  assign bus.stall_count    = w_stallPacked;

  // Response tag lines up with the memory's one-cycle registered read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rrPtr     <= '0;
      r_rspOnehot <= '0;
    end else begin
      r_rspOnehot <= (w_found && !w_grantWrite) ? w_grant : '0;
      if (w_found) begin
        r_rrPtr <= (w_grantIdx == LAST_PORT) ? '0 : w_grantIdx + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_stall
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_stallCnt[i] <= '0;
      end else if (bus.stall_clear) begin
        r_stallCnt[i] <= '0;
      end else if (bus.req_valid[i] && !w_grant[i] && !(&r_stallCnt[i])) begin
        r_stallCnt[i] <= r_stallCnt[i] + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: expected load responses are queued
// at issue time and matched by an independent response monitor.
module tb_memory_port_arbiter;
  localparam int NP  = 4;
  localparam int DW  = 8;
  localparam int AW  = 8;
  localparam int SCW = 4;

  typedef struct packed {
    logic [NP-1:0] onehot;
    logic [DW-1:0] data;
    int            cycle;
  } rspItem_t;

  logic     clk = 1'b0;
  logic     reset;
  int       cyc = 0;
  int       testsRun = 0;
  int       testsFailed = 0;
  rspItem_t expQ[$];
  rspItem_t item;
  logic [DW-1:0] mem [256];

  memory_port_arbiter_if #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .STALL_COUNTER_WIDTH(SCW)
  ) bus ();

  memory_port_arbiter #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .STALL_COUNTER_WIDTH(SCW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered-output memory model; preloads its contents while reset is high.
  always @(posedge clk) begin
    if (reset) begin
      for (int a = 0; a < 256; a++) mem[a] <= '0;
      mem[0]            <= 8'h11;
      mem[1]            <= 8'h22;
      mem[2]            <= 8'h33;
      mem[3]            <= 8'h44;
      mem[8'h10]        <= 8'hAB;
      bus.mem_read_data <= '0;
    end else begin
      if (bus.mem_write) mem[bus.mem_address] <= bus.mem_write_data;
      bus.mem_read_data <= mem[bus.mem_address];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Response monitor: every asserted rsp_valid must match the oldest queued load.
  always @(negedge clk) begin
    if (bus.rsp_valid != '0) begin
      if (expQ.size() == 0) begin
        checkOutput("rsp_unexpected", 32'(bus.rsp_valid), 32'h0);
      end else begin
        item = expQ.pop_front();
        checkOutput("rsp_port",  32'(bus.rsp_valid), 32'(item.onehot));
        checkOutput("rsp_data",  32'(bus.rsp_data),  32'(item.data));
        checkOutput("rsp_cycle", 32'(cyc),           32'(item.cycle));
      end
    end else if (expQ.size() > 0 && expQ[0].cycle <= cyc) begin
      item = expQ.pop_front();
      checkOutput("rsp_missing", 32'(bus.rsp_valid), 32'(item.onehot));
    end
  end

  task automatic applyStimulus(input logic [NP-1:0] valid, input logic [NP-1:0] write,
                               input logic [NP*AW-1:0] addr, input logic [NP*DW-1:0] data,
                               input logic clear);
    @(posedge clk);
    #1;
    bus.req_valid   = valid;
    bus.req_write   = write;
    bus.req_address = addr;
    bus.req_data    = data;
    bus.stall_clear = clear;
  endtask

  task automatic issueAndCheck(input string name, input logic [NP-1:0] valid, input logic [NP-1:0] write,
                               input logic [NP*AW-1:0] addr, input logic [NP*DW-1:0] data,
                               input logic clear, input logic [NP-1:0] expReady, input logic [DW-1:0] expData);
    applyStimulus(valid, write, addr, data, clear);
    @(negedge clk);
    checkOutput(name, 32'(bus.req_ready), 32'(expReady));
    if (expReady != '0 && (expReady & write) == '0) begin
      expQ.push_back('{onehot: expReady, data: expData, cycle: cyc + 1});
    end
  endtask

  task automatic idleCycle(input logic clear);
    applyStimulus('0, '0, '0, '0, clear);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset           = 1'b1;
    bus.req_valid   = '0;
    bus.req_write   = '0;
    bus.req_address = '0;
    bus.req_data    = '0;
    bus.stall_clear = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_rsp_valid",   32'(bus.rsp_valid),   32'h0);
    checkOutput("reset_stall_count", 32'(bus.stall_count), 32'h0);
    checkOutput("reset_req_ready",   32'(bus.req_ready),   32'h0);
    checkOutput("reset_mem_write",   32'(bus.mem_write),   32'h0);
    checkOutput("reset_mem_address", 32'(bus.mem_address), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    // All four ports load addresses 0..3, each dropping out after its grant.
    issueAndCheck("all_grant0", 4'b1111, 4'b0000, {8'd3, 8'd2, 8'd1, 8'd0}, '0, 1'b0, 4'b0001, 8'h11);
    issueAndCheck("all_grant1", 4'b1110, 4'b0000, {8'd3, 8'd2, 8'd1, 8'd0}, '0, 1'b0, 4'b0010, 8'h22);
    issueAndCheck("all_grant2", 4'b1100, 4'b0000, {8'd3, 8'd2, 8'd1, 8'd0}, '0, 1'b0, 4'b0100, 8'h33);
    issueAndCheck("all_grant3", 4'b1000, 4'b0000, {8'd3, 8'd2, 8'd1, 8'd0}, '0, 1'b0, 4'b1000, 8'h44);
    idleCycle(1'b0);
    checkOutput("all_stall_count", 32'(bus.stall_count), 32'h3210);
    checkOutput("idle_mem_address", 32'(bus.mem_address), 32'h0);
    checkOutput("idle_mem_write",   32'(bus.mem_write),   32'h0);
    idleCycle(1'b1);
    idleCycle(1'b0);
    checkOutput("clear_stall_count", 32'(bus.stall_count), 32'h0);

    // Ports 1 and 3 continuously valid from rr_ptr=0: strict alternation.
    for (int i = 0; i < 6; i++) begin
      issueAndCheck($sformatf("rot_grant%0d", i), 4'b1010, 4'b0000, {8'd3, 8'd0, 8'd1, 8'd0}, '0, 1'b0,
                    (i % 2 == 0) ? 4'b0010 : 4'b1000, (i % 2 == 0) ? 8'h22 : 8'h44);
    end
    idleCycle(1'b0);
    checkOutput("rot_stall_count", 32'(bus.stall_count), 32'h3030);
    idleCycle(1'b1);

    issueAndCheck("single_load", 4'b0100, 4'b0000, {8'd0, 8'h10, 8'd0, 8'd0}, '0, 1'b0, 4'b0100, 8'hAB);
    idleCycle(1'b0);
    idleCycle(1'b0);

    // Store from port 0 immediately followed by a load of the same word from port 1.
    issueAndCheck("store_grant", 4'b0001, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd7}, {8'd0, 8'd0, 8'd0, 8'h5A},
                  1'b0, 4'b0001, 8'h00);
    checkOutput("store_mem_write",   32'(bus.mem_write),      32'h1);
    checkOutput("store_mem_address", 32'(bus.mem_address),    32'h7);
    checkOutput("store_mem_wdata",   32'(bus.mem_write_data), 32'h5A);
    issueAndCheck("load_after_store", 4'b0010, 4'b0000, {8'd0, 8'd0, 8'd7, 8'd0}, '0, 1'b0, 4'b0010, 8'h5A);
    idleCycle(1'b0);

    // Ports 0 and 1 keep storing; each stalls every other cycle until saturation.
    for (int i = 0; i < 42; i++) begin
      issueAndCheck($sformatf("sat_grant%0d", i), 4'b0011, 4'b0011, {8'd0, 8'd0, 8'h21, 8'h20},
                    {8'd0, 8'd0, 8'h02, 8'h01}, (i == 40), (i % 2 == 0) ? 4'b0001 : 4'b0010, 8'h00);
      if (i == 29) checkOutput("sat_count_c29",   32'(bus.stall_count), 32'h00FE);
      if (i == 40) checkOutput("sat_count_c40",   32'(bus.stall_count), 32'h00FF);
      if (i == 41) checkOutput("sat_clear_first", 32'(bus.stall_count), 32'h0000);
    end
    idleCycle(1'b0);
    checkOutput("sat_clear_then", 32'(bus.stall_count), 32'h0001);

    // Reset asserted mid-cycle right after a load handshake cancels its response.
    applyStimulus(4'b0100, 4'b0000, {8'd0, 8'd2, 8'd0, 8'd0}, '0, 1'b0);
    @(negedge clk);
    checkOutput("prereset_grant", 32'(bus.req_ready), 32'h4);
    applyStimulus(4'b1100, 4'b0000, {8'd3, 8'd2, 8'd0, 8'd0}, '0, 1'b0);
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("inreset_rsp_valid",   32'(bus.rsp_valid),   32'h0);
    checkOutput("inreset_stall_count", 32'(bus.stall_count), 32'h0);
    checkOutput("inreset_req_ready",   32'(bus.req_ready),   32'h4);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("postreset_grant", 32'(bus.req_ready), 32'h4);
    expQ.push_back('{onehot: 4'b0100, data: 8'h33, cycle: cyc + 1});
    issueAndCheck("postreset_next", 4'b1000, 4'b0000, {8'd3, 8'd0, 8'd0, 8'd0}, '0, 1'b0, 4'b1000, 8'h44);
    checkOutput("postreset_stall", 32'(bus.stall_count), 32'h1000);
    idleCycle(1'b0);
    idleCycle(1'b0);

    checkOutput("queue_empty", 32'(expQ.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
